// File: rtl/can_rx_buffer_if.sv
// Host-facing bundle for the CAN receive buffer: receiver frame input, acceptance
// filter settings, show-ahead read port and status.
interface can_rx_buffer_if #(
   parameter int N  = 4,
   parameter int CW = $clog2(N + 1)
);
   logic                 rx_valid;
   logic [10:0]          rx_id;
   logic [3:0]           rx_dlc;
   logic [7:0][7:0]      rx_data;
   logic [10:0]          acc_code;
   logic [10:0]          acc_mask;
   logic                 re;
   logic                 clr_overrun;
   logic                 out_valid;
   logic [10:0]          out_id;
   logic [3:0]           out_dlc;
   logic [7:0][7:0]      out_data;
   logic                 full;
   logic                 empty;
   logic [CW-1:0]        count;
   logic                 overrun;
   logic                 rx_accept;

   modport master (
      output rx_valid, rx_id, rx_dlc, rx_data, acc_code, acc_mask, re, clr_overrun,
      input  out_valid, out_id, out_dlc, out_data, full, empty, count, overrun, rx_accept
   );

   modport slave (
      input  rx_valid, rx_id, rx_dlc, rx_data, acc_code, acc_mask, re, clr_overrun,
      output out_valid, out_id, out_dlc, out_data, full, empty, count, overrun, rx_accept
   );
endinterface

// File: rtl/can_rx_buffer.sv
// CAN receive buffer: 11-bit code/mask acceptance filter feeding an N-deep
// show-ahead frame FIFO with sticky overrun reporting.
module can_rx_buffer #(
   parameter int N  = 4,
   parameter int CW = $clog2(N + 1)
) (
   input logic            clk,
   input logic            rst,
   can_rx_buffer_if.slave bus
);
   localparam int PW = $clog2(N);

   logic [10:0]     mem_id   [N];
   logic [3:0]      mem_dlc  [N];
   logic [7:0][7:0] mem_data [N];

   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic [CW-1:0] count_next;
   logic          full;
   logic          empty;
   logic          overrun;
   logic          rx_accept;

   logic            match;
   logic            do_pop;
   logic            wr_en;
   logic            drop;
   logic [7:0][7:0] payload;

   assign match  = ((bus.rx_id ^ bus.acc_code) & bus.acc_mask) == 11'h000;
   assign do_pop = bus.re && !empty;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign wr_en  = bus.rx_valid && match && (!full || do_pop);
   assign drop   = bus.rx_valid && match && full && !do_pop;

   // Bytes beyond the DLC are stored as zero; DLC 9..15 keeps all eight bytes.
   always_comb begin
      payload = '0;
      for (int i = 0; i < 8; i++) begin
         if (4'(i) < bus.rx_dlc) payload[i] = bus.rx_data[i];
      end
   end

   always_comb begin
      count_next = count;
      if (wr_en && !do_pop)      count_next = count + CW'(1);
      else if (!wr_en && do_pop) count_next = count - CW'(1);
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         full      <= 1'b0;
         empty     <= 1'b1;
         overrun   <= 1'b0;
         rx_accept <= 1'b0;
      end else begin
         if (wr_en)  wr_ptr <= wr_ptr + PW'(1);
         if (do_pop) rd_ptr <= rd_ptr + PW'(1);
         count     <= count_next;
         full      <= (count_next == CW'(N));
         empty     <= (count_next == '0);
         rx_accept <= wr_en;
         if (drop)                 overrun <= 1'b1;
         else if (bus.clr_overrun) overrun <= 1'b0;
      end
   end

   // NOTE: frame storage has no reset; the pointers and count alone decide
   // which entries are meaningful, so stale contents are never observed.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_id[wr_ptr]   <= bus.rx_id;
         mem_dlc[wr_ptr]  <= bus.rx_dlc;
         mem_data[wr_ptr] <= payload;
      end
   end

   assign bus.out_valid = !empty;
   assign bus.out_id    = empty ? 11'h000 : mem_id[rd_ptr];
   assign bus.out_dlc   = empty ? 4'h0    : mem_dlc[rd_ptr];
   assign bus.out_data  = empty ? '0      : mem_data[rd_ptr];
   assign bus.full      = full;
   assign bus.empty     = empty;
   assign bus.count     = count;
   assign bus.overrun   = overrun;
   assign bus.rx_accept = rx_accept;
endmodule

// File: tb/tb_can_rx_buffer.sv
// Directed bench for can_rx_buffer: a driver queues expected frames and accept
// pulses, and an independent negedge monitor checks every pop against them.
module tb_can_rx_buffer;
   localparam int N = 4;

   logic clk;
   logic rst;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   can_rx_buffer_if #(.N(N)) bus ();

   can_rx_buffer #(.N(N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct packed {
      logic [10:0] id;
      logic [3:0]  dlc;
      logic [63:0] data;
   } frame_t;

   frame_t exp_q[$];
   bit     acc_q[$];
   int     n_checks = 0;
   int     n_pass   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic logic [63:0] mask_payload(input logic [63:0] d, input logic [3:0] dlc);
      logic [63:0] r;
      r = '0;
      for (int i = 0; i < 8; i++) if (i < int'(dlc)) r[8*i +: 8] = d[8*i +: 8];
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [10:0] id, input logic [3:0] dlc, input logic [63:0] data,
                       input bit exp_acc, input bit with_re = 1'b0, input bit with_clr = 1'b0);
      bus.rx_valid    = 1'b1;
      bus.rx_id       = id;
      bus.rx_dlc      = dlc;
      bus.rx_data     = data;
      bus.re          = with_re;
      bus.clr_overrun = with_clr;
      acc_q.push_back(exp_acc);
      if (exp_acc) exp_q.push_back('{id, dlc, mask_payload(data, dlc)});
      tick();
      bus.rx_valid    = 1'b0;
      bus.re          = 1'b0;
      bus.clr_overrun = 1'b0;
   endtask

   task automatic pop();
      bus.re = 1'b1;
      tick();
      bus.re = 1'b0;
   endtask

   // Monitor: mid-cycle sampling of accept pulses and of every head frame popped.
   initial begin
      bit     pend;
      bit     pend_exp;
      frame_t f;
      pend     = 1'b0;
      pend_exp = 1'b0;
      forever begin
         @(negedge clk);
         if (pend) begin
            check("rx_accept_pulse", bus.rx_accept, pend_exp);
            pend = 1'b0;
         end
         if (rst && bus.rx_valid) begin
            pend     = 1'b1;
            pend_exp = (acc_q.size() != 0) ? acc_q.pop_front() : 1'b0;
         end
         if (rst && bus.re && bus.out_valid) begin
            check("pop_has_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
               f = exp_q.pop_front();
               check("pop_id",   bus.out_id,   f.id);
               check("pop_dlc",  bus.out_dlc,  f.dlc);
               check("pop_data", bus.out_data, f.data);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst             = 1'b0;
      bus.rx_valid    = 1'b0;
      bus.rx_id       = '0;
      bus.rx_dlc      = '0;
      bus.rx_data     = '0;
      bus.acc_code    = '0;
      bus.acc_mask    = '0;
      bus.re          = 1'b0;
      bus.clr_overrun = 1'b0;
      repeat (2) tick();

      check("rst_count",     bus.count,     0);
      check("rst_empty",     bus.empty,     1);
      check("rst_full",      bus.full,      0);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_overrun",   bus.overrun,   0);
      check("rst_rx_accept", bus.rx_accept, 0);
      rst = 1'b1;
      tick();

      // Single frame, short DLC: bytes past the DLC read back as zero.
      send(11'h123, 4'd3, 64'h1122_3344_55CC_BBAA, 1'b1);
      check("t1_out_valid", bus.out_valid, 1);
      check("t1_out_id",    bus.out_id,    11'h123);
      check("t1_out_dlc",   bus.out_dlc,   3);
      check("t1_out_data",  bus.out_data,  64'h0000_0000_00CC_BBAA);
      check("t1_count",     bus.count,     1);
      check("t1_rx_accept", bus.rx_accept, 1);
      pop();
      check("t1_empty",    bus.empty,    1);
      check("t1_out_id0",  bus.out_id,   0);
      check("t1_out_data0", bus.out_data, 0);

      // Acceptance filter: code 0x100, mask 0x7F0.
      bus.acc_code = 11'h100;
      bus.acc_mask = 11'h7F0;
      send(11'h105, 4'd1, 64'h0000_0000_0000_0051, 1'b1);
      send(11'h20F, 4'd1, 64'h0000_0000_0000_0052, 1'b0);
      send(11'h10A, 4'd1, 64'h0000_0000_0000_0053, 1'b1);
      check("t2_count",   bus.count,   2);
      check("t2_overrun", bus.overrun, 0);
      check("t2_head_id", bus.out_id,  11'h105);
      pop();
      pop();
      check("t2_empty", bus.empty, 1);
      bus.acc_code = '0;
      bus.acc_mask = '0;

      // Fill, drop the fifth, then a drop together with clear keeps overrun set.
      for (int i = 1; i <= 5; i++) begin
         send(11'(i), 4'd8, {8{8'(i)}}, i <= 4);
         if (i == 4) begin
            check("t3_full",  bus.full,  1);
            check("t3_count", bus.count, 4);
         end
      end
      check("t3_overrun",     bus.overrun,   1);
      check("t3_drop_accept", bus.rx_accept, 0);
      check("t3_drop_count",  bus.count,     4);
      send(11'd6, 4'd8, 64'h6666_6666_6666_6666, 1'b0, 1'b0, 1'b1);
      check("t3_set_wins", bus.overrun, 1);
      repeat (4) pop();
      check("t3_drained", bus.empty, 1);
      bus.clr_overrun = 1'b1;
      tick();
      bus.clr_overrun = 1'b0;
      check("t3_cleared", bus.overrun, 0);

      // Write into a full FIFO together with a pop.
      for (int i = 1; i <= 4; i++) send(11'(i), 4'd2, {8{8'(16 + i)}}, 1'b1);
      send(11'd9, 4'd2, 64'h0000_0000_0000_9999, 1'b1, 1'b1);
      check("t4_count",   bus.count,   4);
      check("t4_full",    bus.full,    1);
      check("t4_overrun", bus.overrun, 0);
      check("t4_head_id", bus.out_id,  11'd2);
      repeat (4) pop();

      // Pointer wrap-around over four rounds of three.
      for (int r = 0; r < 4; r++) begin
         for (int k = 0; k < 3; k++)
            send(11'(10 + 3 * r + k), 4'd4, {8{8'(40 + 3 * r + k)}}, 1'b1);
         repeat (3) pop();
         check("t5_count_round", bus.count, 0);
      end

      // Reset while holding three frames with overrun set.
      for (int i = 1; i <= 5; i++) send(11'(32 + i), 4'd1, {8{8'(i)}}, i <= 4);
      pop();
      check("t6_pre_count",   bus.count,   3);
      check("t6_pre_overrun", bus.overrun, 1);
      rst = 1'b0;
      exp_q.delete();
      tick();
      rst = 1'b1;
      check("t6_count",   bus.count,   0);
      check("t6_empty",   bus.empty,   1);
      check("t6_full",    bus.full,    0);
      check("t6_overrun", bus.overrun, 0);
      send(11'h7FF, 4'd2, 64'h0000_0000_0000_BEEF, 1'b1);
      check("t6_id_7ff", bus.out_id, 11'h7FF);
      check("t6_count1", bus.count,  1);
      pop();
      pop();
      check("t6_empty_pop_count", bus.count, 0);
      check("t6_empty_pop_empty", bus.empty, 1);
      send(11'h055, 4'd12, 64'h8877_6655_4433_2211, 1'b1);
      check("t6_dlc12_id",   bus.out_id,   11'h055);
      check("t6_dlc12_dlc",  bus.out_dlc,  12);
      check("t6_dlc12_data", bus.out_data, 64'h8877_6655_4433_2211);
      pop();
      tick();

      check("scoreboard_drained", 64'(exp_q.size()), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/can_rx_buffer.md
Name: can_rx_buffer

Overview:
Receive-side message buffer for the CAN controller, the counterpart of the transmit priority queue. It takes completed frames from the bit-level receiver and applies an 11-bit acceptance code/mask filter. Accepted frames are stored in arrival order in an N-deep FIFO. The host pops frames through a show-ahead read port, and buffer overflow is reported with a sticky overrun flag.

Parameters:
N, 4, FIFO depth in frames (N >= 2, power of two).
CW, $clog2(N+1), width of the occupancy count.

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  reset, synchronous and active-low (rst=0 resets on the next rising clk)
rx_valid  in  1  one-cycle pulse: a complete, CRC-good frame is on rx_id/rx_dlc/rx_data
rx_id  in  11  received standard identifier
rx_dlc  in  4  received DLC (0..15)
rx_data  in  8x8  received payload bytes, index 0 first
acc_code  in  11  acceptance code
acc_mask  in  11  acceptance mask, 1 = bit compared, 0 = don't care
re  in  1  host read/pop strobe
clr_overrun  in  1  clears the overrun flag
out_valid  out  1  head frame available (equals !empty)
out_id  out  11  head frame identifier
out_dlc  out  4  head frame DLC as received
out_data  out  8x8  head frame payload
full  out  1  FIFO holds N frames
empty  out  1  FIFO holds 0 frames
count  out  CW  number of stored frames
overrun  out  1  sticky: an accepted frame was dropped because the FIFO was full
rx_accept  out  1  one-cycle pulse: the frame presented on the previous rx_valid was written into the FIFO

Behaviour:
- Reset (rst=0 at a clk edge) forces:
  - wr_ptr=0, rd_ptr=0, count=0;
  - empty=1, full=0, out_valid=0, overrun=0, rx_accept=0.
  - Storage contents are don't-care.
  - Reset dominates all other inputs in the same cycle, including mid-stream traffic: every frame in flight or stored is discarded.
- Filter (combinational on the rx_* inputs): match = ((rx_id ^ acc_code) & acc_mask) == 0. acc_mask=0 accepts all frames.
- Write: at a clk edge with rx_valid=1 and match=1:
  - If not full, or if re=1 is popping in the same cycle: store {rx_id, rx_dlc, data}, increment wr_ptr modulo N, and pulse rx_accept=1 in the following cycle.
  - Stored data byte i equals rx_data[i] for i < min(rx_dlc, 8) and 0 otherwise. DLC 9..15 stores 8 bytes and keeps the raw DLC.
  - If full and no pop in that cycle: frame dropped, overrun<=1, rx_accept stays 0.
- Non-matching frames are ignored silently: no overrun, no rx_accept.
- Read: show-ahead. out_id/out_dlc/out_data always reflect the entry at rd_ptr.
  - When empty=1 these outputs are forced to 0.
  - re=1 at a clk edge with empty=0 pops the head (rd_ptr+1 mod N).
  - re with empty=1 is ignored, with no error and no state change.
- Latency: a frame written at edge k is visible (out_valid=1, correct fields) after edge k when the FIFO was empty. Fall-through is 1 cycle; rx inputs never combinationally reach the outputs.
- Simultaneous write and read:
  - Non-empty FIFO: count unchanged, both pointers advance.
  - Empty FIFO: the read is ignored, the write proceeds, count becomes 1.
  - Full FIFO: the pop frees a slot and the write is accepted, so count stays N and no overrun is raised.
- count/full/empty are registered and consistent every cycle:
  - full = (count == N);
  - empty = (count == 0).
- Pointers wrap modulo N and arrival order is preserved across wrap-around.
- overrun:
  - Set by a dropped frame and held until clr_overrun=1 at a clk edge.
  - If a drop and clr_overrun occur in the same cycle, set wins (overrun=1).
- acc_code/acc_mask may change at any time. They take effect on the next rx_valid and never affect frames already stored.

Test Plan:
- Reset, then acc_mask=0 and rx_valid with id=0x123, dlc=3, data={AA,BB,CC,..} -> after the next edge: out_valid=1, out_id=0x123, out_dlc=3, out_data={AA,BB,CC,0,0,0,0,0}, count=1, rx_accept pulse. Then re -> empty=1, out_id=0.
- acc_code=0x100, acc_mask=0x7F0; send ids 0x105, 0x20F, 0x10A -> only 0x105 and 0x10A are stored, in that order, with count=2 and overrun=0.
- N=4: push ids 1..5 with no reads -> full=1 after the 4th, 5th dropped, overrun=1. Pop all four -> ids 1,2,3,4 in order. clr_overrun -> overrun=0.
- Full FIFO: rx_valid id=9 together with re -> head id 1 popped, id 9 stored, count stays 4, overrun=0. Drain order 2,3,4,9.
- Wrap-around: repeat push 3 / pop 3 for 4 rounds with ids 10..21 -> output order 10..21 exactly, and count returns to 0 each round.
- Reset mid-operation: with 3 stored frames, rst=0 for one cycle -> count=0, empty=1, overrun=0. A subsequent push of id 0x7FF reads back correctly. re on empty -> no change. rx_dlc=12 -> out_dlc=12 with all 8 bytes stored.
